// File: rtl/cnt_trigger.sv
// cnt_trigger: masked compare on the free-running board counter, with an
// occurrence counter, one-cycle trigger strobe, sticky trigger flag, captured
// counter value and a hold-off window before the next arm is accepted.
//
// Pipeline: stage 1 registers the compare result (hit_reg) together with the
// counter sample that produced it (cnt_reg); stage 2 is the arm/trigger FSM,
// which consumes hit_reg and captures cnt_reg on the firing hit.
module cnt_trigger #(
    parameter int CNT_W  = 32,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              arm,
    input  logic              disarm,
    input  logic [CNT_W-1:0]  match_val,
    input  logic [CNT_W-1:0]  match_mask,
    input  logic [1:0]        trig_mode,
    input  logic [7:0]        trig_count,
    input  logic [HOLD_W-1:0] holdoff,
    output logic              armed,
    output logic              busy,
    output logic              trig_pulse,
    output logic              trig_level,
    output logic [CNT_W-1:0]  cap_val,
    output logic [7:0]        occ_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Stage 1: masked compare
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_masked;
    logic [CNT_W-1:0] val_masked;
    logic             hit_next;
    logic             hit_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Bits with a 0 in the mask are forced to 0 on both sides so they never
    // influence the compare; with an all-zero mask, equal always holds and
    // not-equal / greater-than never do.
    genvar gi;
    generate
        for (gi = 0; gi < CNT_W; gi++) begin : g_mask
            assign cnt_masked[gi] = cnt_in[gi]    & match_mask[gi];
            assign val_masked[gi] = match_val[gi] & match_mask[gi];
        end
    endgenerate

    // Compare selected by trig_mode; mode 11 aliases masked-equal.
    always_comb begin
        hit_next = 1'b0;
        case (trig_mode)
            2'b01:   hit_next = (cnt_masked != val_masked);
            2'b10:   hit_next = (cnt_masked >  val_masked);
            default: hit_next = (cnt_masked == val_masked);
        endcase
    end

    // Compare register: hit flag plus the sample it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            hit_reg <= hit_next;
            cnt_reg <= cnt_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: arm / trigger FSM
    // ------------------------------------------------------------------
    state_t            state_reg,  state_next;
    logic [7:0]        occ_reg,    occ_next;
    logic              level_reg,  level_next;
    logic [CNT_W-1:0]  cap_reg,    cap_next;
    logic [HOLD_W-1:0] hold_reg,   hold_next;

    logic [7:0] occ_inc;
    logic [7:0] thr;

    // Saturating hit count and the effective threshold (0 behaves as 1).
    assign occ_inc = (occ_reg == 8'hFF) ? 8'hFF : occ_reg + 8'd1;
    assign thr     = (trig_count == 8'd0) ? 8'd1 : trig_count;

    // State register and the datapath registers the FSM owns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            occ_reg   <= 8'd0;
            level_reg <= 1'b0;
            cap_reg   <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            occ_reg   <= occ_next;
            level_reg <= level_next;
            cap_reg   <= cap_next;
            hold_reg  <= hold_next;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_next = state_reg;
        occ_next   = occ_reg;
        level_next = level_reg;
        cap_next   = cap_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE: begin
                // disarm wins over a simultaneous arm
                if (arm && !disarm) begin
                    state_next = ARMED;
                    occ_next   = 8'd0;
                    level_next = 1'b0;
                end
            end
            ARMED: begin
                // an abort suppresses any hit presented in the same cycle
                if (disarm) begin
                    state_next = IDLE;
                end else if (hit_reg) begin
                    occ_next = occ_inc;
                    if (occ_inc >= thr) begin
                        state_next = TRIGGERED;
                        level_next = 1'b1;
                        cap_next   = cnt_reg;
                    end
                end
            end
            TRIGGERED: begin
                hold_next  = holdoff;
                state_next = (holdoff == '0) ? IDLE : HOLDOFF;
            end
            HOLDOFF: begin
                // leaving when the counter reads 1 gives exactly 'holdoff' cycles here
                hold_next = hold_reg - HOLD_W'(1);
                if (hold_reg == HOLD_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decodes of the registered state.
    always_comb begin
        armed      = (state_reg == ARMED);
        busy       = (state_reg == TRIGGERED) || (state_reg == HOLDOFF);
        trig_pulse = (state_reg == TRIGGERED);
        trig_level = level_reg;
        cap_val    = cap_reg;
        occ_cnt    = occ_reg;
    end

endmodule

// File: tb/tb_cnt_trigger.sv
// tb_cnt_trigger: table-driven equality-fire vectors, then model-driven
// scoreboard sequences for the occurrence, disarm, hold-off, wrap and reset cases.
module tb_cnt_trigger;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cnt_in = '0;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic [31:0] match_val = '0;
    logic [31:0] match_mask = '0;
    logic [1:0]  trig_mode = '0;
    logic [7:0]  trig_count = '0;
    logic [15:0] holdoff = '0;
    logic        armed, busy, trig_pulse, trig_level;
    logic [31:0] cap_val;
    logic [7:0]  occ_cnt;

    cnt_trigger #(.CNT_W(32), .HOLD_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .arm        (arm),
        .disarm     (disarm),
        .match_val  (match_val),
        .match_mask (match_mask),
        .trig_mode  (trig_mode),
        .trig_count (trig_count),
        .holdoff    (holdoff),
        .armed      (armed),
        .busy       (busy),
        .trig_pulse (trig_pulse),
        .trig_level (trig_level),
        .cap_val    (cap_val),
        .occ_cnt    (occ_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        armed;
        logic        busy;
        logic        pulse;
        logic        level;
        logic [31:0] cap;
        logic [7:0]  occ;
    } exp_t;

    typedef struct packed {
        logic        arm;
        logic        disarm;
        logic [31:0] cnt;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[16];

    int n_checks = 0;
    int n_errs   = 0;

    // reference model state (0 idle, 1 armed, 2 triggered, 3 holdoff)
    int          m_state;
    logic        m_hit;
    logic [31:0] m_cnt;
    logic [31:0] m_cap;
    int          m_occ;
    int          m_hold;
    logic        m_level;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_hit = 1'b0; m_cnt = '0; m_cap = '0;
        m_occ = 0; m_hold = 0; m_level = 1'b0;
    endtask

    task automatic model_step(input logic a, input logic d, input logic [31:0] c);
        int ns;
        int thr;
        logic [31:0] am;
        logic [31:0] bm;
        ns  = m_state;
        thr = (trig_count == 8'd0) ? 1 : int'(trig_count);
        case (m_state)
            0: if (a && !d) begin ns = 1; m_occ = 0; m_level = 1'b0; end
            1: if (d) ns = 0;
               else if (m_hit) begin
                   if (m_occ < 255) m_occ++;
                   if (m_occ >= thr) begin ns = 2; m_level = 1'b1; m_cap = m_cnt; end
               end
            2: begin m_hold = int'(holdoff); ns = (m_hold == 0) ? 0 : 3; end
            default: begin if (m_hold == 1) ns = 0; m_hold--; end
        endcase
        am = c & match_mask;
        bm = match_val & match_mask;
        if (trig_mode == 2'b01)      m_hit = (am != bm);
        else if (trig_mode == 2'b10) m_hit = (am > bm);
        else                         m_hit = (am == bm);
        m_cnt   = c;
        m_state = ns;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.armed = (m_state == 1);
        e.busy  = (m_state >= 2);
        e.pulse = (m_state == 2);
        e.level = m_level;
        e.cap   = m_cap;
        e.occ   = 8'(m_occ);
        return e;
    endfunction

    task automatic compare_pop(input string tag);
        exp_t e;
        $display("%s cnt=%h arm=%b dis=%b -> armed=%b busy=%b pulse=%b level=%b cap=%h occ=%0d",
                 tag, cnt_in, arm, disarm, armed, busy, trig_pulse, trig_level, cap_val, occ_cnt);
        if (sb_q.size() == 0) begin
            n_checks++; n_errs++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        chk_b({tag, " armed"}, armed, e.armed);
        chk_b({tag, " busy"}, busy, e.busy);
        chk_b({tag, " trig_pulse"}, trig_pulse, e.pulse);
        chk_b({tag, " trig_level"}, trig_level, e.level);
        chk_w({tag, " cap_val"}, cap_val, e.cap);
        chk_w({tag, " occ_cnt"}, 32'(occ_cnt), 32'(e.occ));
    endtask

    // drive one cycle of stimulus, predict with the model, compare after the edge
    task automatic step(input logic a, input logic d, input logic [31:0] c, input string tag);
        arm = a; disarm = d; cnt_in = c;
        model_step(a, d, c);
        sb_q.push_back(model_exp());
        @(posedge clk); #1;
        compare_pop(tag);
    endtask

    task automatic cfg(input logic [31:0] mask, input logic [31:0] val, input logic [1:0] mode,
                       input logic [7:0] tc, input logic [15:0] ho);
        match_mask = mask; match_val = val; trig_mode = mode; trig_count = tc; holdoff = ho;
    endtask

    task automatic rst_check(input string tag);
        chk_b({tag, " armed"}, armed, 1'b0);
        chk_b({tag, " busy"}, busy, 1'b0);
        chk_b({tag, " trig_pulse"}, trig_pulse, 1'b0);
        chk_b({tag, " trig_level"}, trig_level, 1'b0);
        chk_w({tag, " cap_val"}, cap_val, 32'h0);
        chk_w({tag, " occ_cnt"}, 32'(occ_cnt), 32'h0);
    endtask

    // assert reset between edges, check outputs clear at once, release on a falling edge
    task automatic do_reset(input string tag);
        arm = 1'b0; disarm = 1'b0;
        #1 rst = 1'b1;
        #1 rst_check(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int busy_rows;

        // equality fire table: arm at cnt 0x08, match 0x10, holdoff 4
        for (int i = 0; i < 16; i++) begin
            vecs[i].arm       = (i == 0);
            vecs[i].disarm    = 1'b0;
            vecs[i].cnt       = 32'h08 + 32'(i);
            vecs[i].exp.armed = (i <= 8);
            vecs[i].exp.busy  = (i >= 9) && (i <= 13);
            vecs[i].exp.pulse = (i == 9);
            vecs[i].exp.level = (i >= 9);
            vecs[i].exp.cap   = (i >= 9) ? 32'h10 : 32'h0;
            vecs[i].exp.occ   = (i >= 9) ? 8'd1 : 8'd0;
        end

        model_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst_check("reset");
        @(negedge clk);
        rst = 1'b0;

        cfg(32'hFFFF_FFFF, 32'h10, 2'b00, 8'd1, 16'd4);
        for (int i = 0; i < 16; i++) begin
            arm = vecs[i].arm; disarm = vecs[i].disarm; cnt_in = vecs[i].cnt;
            sb_q.push_back(vecs[i].exp);
            @(posedge clk); #1;
            compare_pop($sformatf("eq_tbl[%0d]", i));
        end

        // occurrence count: third low-nibble-3 value fires
        do_reset("rst_a");
        cfg(32'h0000_000F, 32'h3, 2'b00, 8'd3, 16'd2);
        for (int i = 0; i < 48; i++) step(i == 0, 1'b0, 32'(i), "occ");
        chk_w("occ cap_val", cap_val, 32'h23);
        chk_w("occ cap nibble", {28'h0, cap_val[3:0]}, 32'h3);
        chk_w("occ occ_cnt", 32'(occ_cnt), 32'd3);

        // disarm in the same cycle the hit reaches the FSM
        do_reset("rst_b");
        cfg(32'hFFFF_FFFF, 32'h5, 2'b00, 8'd1, 16'd4);
        for (int i = 0; i <= 5; i++) step(i == 0, 1'b0, 32'(i), "race");
        step(1'b0, 1'b1, 32'h6, "race_dis");
        step(1'b1, 1'b1, 32'h7, "race_both");
        step(1'b0, 1'b0, 32'h8, "race_idle");
        chk_b("race armed", armed, 1'b0);
        chk_b("race trig_level", trig_level, 1'b0);
        chk_w("race occ_cnt", 32'(occ_cnt), 32'd0);

        // hold-off lockout with arm held high every cycle
        do_reset("rst_c");
        cfg(32'hFFFF_FFFF, 32'h3, 2'b00, 8'd1, 16'd10);
        busy_rows = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'(i), "lock");
            if (busy) busy_rows++;
        end
        chk_w("lock busy cycles", 32'(busy_rows), 32'd11);
        chk_b("lock rearmed", armed, 1'b1);
        chk_b("lock level cleared", trig_level, 1'b0);

        // greater-than across the counter wrap
        do_reset("rst_d");
        cfg(32'hFFFF_FFFF, 32'hFFFF_FFF0, 2'b10, 8'd1, 16'd2);
        for (int i = 0; i < 38; i++) step(i == 0, 1'b0, 32'hFFFF_FFE0 + 32'(i), "gt");
        chk_w("gt cap_val", cap_val, 32'hFFFF_FFF1);
        chk_b("gt trig_level", trig_level, 1'b1);

        do_reset("rst_e");
        cfg(32'hFFFF_FFFF, 32'hFFFF_FFF0, 2'b10, 8'd20, 16'd2);
        for (int i = 0; i < 34; i++) step(i == 0, 1'b0, 32'hFFFF_FFE0 + 32'(i), "gt20");
        step(1'b0, 1'b1, 32'h2, "gt20_dis");
        step(1'b0, 1'b0, 32'h3, "gt20_idle");
        chk_w("gt20 occ_cnt", 32'(occ_cnt), 32'd15);
        chk_b("gt20 armed", armed, 1'b0);
        chk_b("gt20 trig_level", trig_level, 1'b0);

        // reset while armed with two hits counted
        do_reset("rst_f");
        cfg(32'h0000_000F, 32'h3, 2'b00, 8'd5, 16'd4);
        for (int i = 0; i <= 20; i++) step(i == 0, 1'b0, 32'(i), "ra");
        chk_w("ra occ_cnt", 32'(occ_cnt), 32'd2);
        chk_b("ra armed", armed, 1'b1);
        do_reset("ra_rst");
        for (int i = 21; i < 25; i++) step(1'b0, 1'b0, 32'(i), "ra_post");

        // reset during hold-off
        cfg(32'hFFFF_FFFF, 32'h3, 2'b00, 8'd1, 16'd10);
        for (int i = 0; i <= 8; i++) step(i == 0, 1'b0, 32'(i), "rh");
        chk_b("rh busy", busy, 1'b1);
        do_reset("rh_rst");
        for (int i = 9; i < 14; i++) step(1'b0, 1'b0, 32'(i), "rh_post");

        // trig_count 0 behaves as 1, holdoff 0 returns straight to idle
        cfg(32'hFFFF_FFFF, 32'h3, 2'b00, 8'd0, 16'd0);
        for (int i = 0; i <= 8; i++) step(i == 0, 1'b0, 32'(i), "tc0");
        chk_w("tc0 occ_cnt", 32'(occ_cnt), 32'd1);
        chk_w("tc0 cap_val", cap_val, 32'h3);
        chk_b("tc0 trig_level", trig_level, 1'b1);
        chk_b("tc0 busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/cnt_trigger.md
Name: cnt_trigger

Overview:
- Trigger stage directly downstream of the free-running 32-bit board counter.
- Samples the counter value every clock and compares it, under a mask, against a programmable match value.
- Counts qualifying hits and raises a trigger pulse and a sticky flag; captures the counter value that fired.
- Uses a hold-off window before the next arm is accepted.
- Drives status LEDs and gates capture logic in the debug build.

Parameters:
- CNT_W, 32, width of counter input, match, mask and capture.
- HOLD_W, 16, width of hold-off down-counter.

Ports:
- clk  input  1  single clock, rising-edge; same domain as the counter.
- rst  input  1  asynchronous, active-high reset.
- cnt_in  input  CNT_W  counter value, new value every cycle.
- arm  input  1  request to arm; honoured only in IDLE.
- disarm  input  1  abort; returns to IDLE from ARMED.
- match_val  input  CNT_W  compare value.
- match_mask  input  CNT_W  1 = bit participates in compare.
- trig_mode  input  2  00 masked equal, 01 masked not-equal, 10 masked greater-than (unsigned), 11 same as 00.
- trig_count  input  8  hits required to fire; 0 treated as 1.
- holdoff  input  HOLD_W  cycles spent in HOLDOFF after a trigger.
- armed  output  1  high while in ARMED.
- busy  output  1  high in TRIGGERED or HOLDOFF.
- trig_pulse  output  1  one-cycle trigger strobe.
- trig_level  output  1  sticky trigger flag; cleared on accepted arm.
- cap_val  output  CNT_W  cnt_in sample that produced the firing hit.
- occ_cnt  output  8  hits counted in the current arm session, saturating at 255.

Behaviour:
- Reset (async, active-high) sets:
  - state = IDLE
  - armed, busy, trig_pulse, trig_level = 0
  - cap_val = 0, occ_cnt = 0
  - internal hit_q, cnt_q, and hold-off counter = 0
- Stage 1 (compare register), every cycle:
  - a = cnt_in & match_mask; b = match_val & match_mask.
  - hit_q <= (a==b), (a!=b) or (a>b) according to trig_mode.
  - cnt_q <= cnt_in.
- Stage 2 (FSM), registered outputs. For a cnt_in value in cycle N:
  - hit_q is high in N+1.
  - trig_pulse and cap_val update at the end of N+1 and are visible in N+2.
- IDLE:
  - arm=1 and disarm=0 -> ARMED; occ_cnt <= 0, trig_level <= 0.
  - arm and disarm together -> stay in IDLE (disarm wins).
- ARMED:
  - disarm=1 -> IDLE. No trigger, even if hit_q is high the same cycle. occ_cnt is held.
  - Otherwise, on hit_q=1: occ_cnt increments (saturating).
  - When the incremented count >= max(trig_count,1): trig_pulse <= 1, trig_level <= 1, cap_val <= cnt_q, state -> TRIGGERED.
  - The hit_q present in the first ARMED cycle counts. It reflects cnt_in from the arm cycle.
- TRIGGERED (exactly 1 cycle):
  - trig_pulse is high during this cycle only.
  - Hold-off counter <= holdoff; state -> HOLDOFF.
  - If holdoff==0, go directly to IDLE.
- HOLDOFF:
  - Counter decrements each cycle; state -> IDLE in the cycle it reads 1.
  - Residency is exactly holdoff cycles.
  - arm and disarm are ignored in TRIGGERED and HOLDOFF.
- Output decodes:
  - armed = (state==ARMED).
  - busy = (state==TRIGGERED or HOLDOFF).
  - trig_level persists through HOLDOFF and IDLE until the next accepted arm.
- Boundary cases:
  - match_mask = 0: mode 00 hits every cycle; modes 01 and 10 never hit.
  - Counter wrap 0xFFFFFFFF -> 0: no special handling; compares are on raw values.
  - Inputs match_val, match_mask, trig_mode and trig_count may change while ARMED and take effect on the next compare.
  - rst asserted mid-session (any state) forces the reset values immediately. No trig_pulse is generated on release.

Test Plan:
- Equality fire: mask=0xFFFFFFFF, match=0x10, mode 00, trig_count=1, holdoff=4. Arm at cnt=0x08; cnt increments by 1 per clock.
  -> trig_pulse is high for exactly 1 cycle, 2 cycles after cnt_in=0x10.
  -> cap_val=0x10, trig_level=1, busy for 5 cycles (1 TRIGGERED + 4 HOLDOFF), then IDLE.
- Occurrence count: mask=0x0000000F, match=0x3, trig_count=3.
  -> fires on the third cnt with low nibble 3 after arming.
  -> cap_val low nibble = 3, occ_cnt = 3.
- Disarm race: armed; disarm asserted in the same cycle as hit_q.
  -> no trig_pulse, state IDLE, trig_level stays 0.
  -> arm+disarm together in IDLE -> remains IDLE.
- Hold-off lockout: arm pulsed every cycle during HOLDOFF with holdoff=10.
  -> armed stays 0 until IDLE is reached; the next arm is accepted and clears trig_level.
- Greater-than with wrap: mode 10, mask all ones, match=0xFFFFFFF0, cnt_in from 0xFFFFFFE0 through wrap to 0x5.
  -> fires at cnt 0xFFFFFFF1, cap_val=0xFFFFFFF1.
  -> with trig_count=20 and disarm asserted just after wrap: no fire, occ_cnt=15.
- Reset mid-operation: rst asserted while ARMED with occ_cnt=2, and again during HOLDOFF.
  -> all outputs return to reset values asynchronously; no pulse after release.
  -> trig_count=0 on re-arm behaves as 1.
